// File: rtl/or1200_wb_pkg.sv
// Shared Wishbone slave definitions: FSM state encoding, default parameters
// and the address-decode helper used by the RAM responder.
package or1200_wb_pkg;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_WAIT = 2'd1,
    WB_TERM = 2'd2
  } wb_state_t;

  localparam int unsigned DEF_MEM_WORDS   = 1024;
  localparam int unsigned DEF_WAIT_STATES = 1;
  localparam logic [31:0] DEF_BASE_ADDR   = 32'h0000_0000;

  // Misaligned or outside [base, limit) terminates with an error.
  function automatic logic addr_err(input logic [31:0] adr,
                                    input logic [31:0] base,
                                    input logic [32:0] limit);
    return (adr[1:0] != 2'b00) ||
           ({1'b0, adr} < {1'b0, base}) ||
           ({1'b0, adr} >= limit);
  endfunction

endpackage

// File: rtl/or1200_wb_ram_array.sv
// Single-port word RAM with per-byte write enables and registered read.
// Each byte lane is its own array so the tools can map lanes onto block RAM.
module or1200_wb_ram_array #(
  parameter int unsigned WORDS = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    we_lanes,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [WORDS];
    logic [7:0] rd_reg;

    always_ff @(posedge clk) begin
      if (we_lanes[gi]) begin
        lane_mem[addr] <= wdata[gi*8 +: 8];
      end
      rd_reg <= lane_mem[addr];
    end

    assign rdata[gi*8 +: 8] = rd_reg;
  end

endmodule

// File: rtl/or1200_wb_ram_slave.sv
// Wishbone classic RAM responder with a configurable number of wait states,
// address-range/alignment error termination and byte-lane writes.
module or1200_wb_ram_slave
  import or1200_wb_pkg::*;
#(
  parameter int unsigned MEM_WORDS   = DEF_MEM_WORDS,
  parameter int unsigned WAIT_STATES = DEF_WAIT_STATES,
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o
);

  localparam int unsigned AW    = $clog2(MEM_WORDS);
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(MEM_WORDS) * 33'd4;

  logic [1:0]  rst_sync;
  logic        run;

  wb_state_t   state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] adr_reg, adr_next;
  logic        we_reg, we_next;
  logic [3:0]  sel_reg, sel_next;
  logic [31:0] dat_reg, dat_next;
  logic        ack_reg, ack_next;
  logic        err_reg, err_next;

  logic        req;
  logic [31:0] cur_adr;
  logic        cur_err;
  logic [3:0]  mem_we;
  logic [31:0] rd_data;

  // Release is synchronised; assertion is immediate.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign run = rst_sync[1];
  assign req = wb_cyc_i & wb_stb_i;

  // In IDLE the live address feeds the RAM so a zero-wait read has data in TERM.
  assign cur_adr = (state_reg == WB_IDLE) ? wb_adr_i : adr_reg;
  assign cur_err = addr_err(cur_adr, BASE_ADDR, LIMIT);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    adr_next   = adr_reg;
    we_next    = we_reg;
    sel_next   = sel_reg;
    dat_next   = dat_reg;
    ack_next   = 1'b0;
    err_next   = 1'b0;
    mem_we     = 4'b0000;

    case (state_reg)
      WB_IDLE: begin
        if (run && req) begin
          adr_next = wb_adr_i;
          we_next  = wb_we_i;
          sel_next = wb_sel_i;
          dat_next = wb_dat_i;
          cnt_next = 4'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            state_next = WB_TERM;
            ack_next   = ~cur_err;
            err_next   = cur_err;
          end else begin
            state_next = WB_WAIT;
          end
        end
      end
      WB_WAIT: begin
        if (!req) begin
          state_next = WB_IDLE;
          cnt_next   = 4'd0;
        end else if (cnt_reg <= 4'd1) begin
          state_next = WB_TERM;
          cnt_next   = 4'd0;
          ack_next   = ~cur_err;
          err_next   = cur_err;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      WB_TERM: begin
        state_next = WB_IDLE;
        if (req && ack_reg && we_reg) begin
          mem_we = sel_reg;
        end
      end
      default: state_next = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg <= WB_IDLE;
      cnt_reg   <= 4'd0;
      adr_reg   <= 32'd0;
      we_reg    <= 1'b0;
      sel_reg   <= 4'd0;
      dat_reg   <= 32'd0;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      adr_reg   <= adr_next;
      we_reg    <= we_next;
      sel_reg   <= sel_next;
      dat_reg   <= dat_next;
      ack_reg   <= ack_next;
      err_reg   <= err_next;
    end
  end

  or1200_wb_ram_array #(
    .WORDS(MEM_WORDS),
    .AW   (AW)
  ) u_ram (
    .clk     (clk_i),
    .addr    (cur_adr[AW+1:2]),
    .we_lanes(mem_we),
    .wdata   (dat_reg),
    .rdata   (rd_data)
  );

  assign wb_ack_o = ack_reg;
  assign wb_err_o = err_reg;
  assign wb_dat_o = (ack_reg && !we_reg) ? rd_data : 32'd0;

endmodule

// File: tb/tb_or1200_wb_ram_slave.sv
// Scoreboard bench for or1200_wb_ram_slave: three instances with 1, 3 and 0
// wait states; the driver queues expected terminations, the monitor checks them.
module tb_or1200_wb_ram_slave;

  logic        clk = 1'b0;
  logic [2:0]  rst_n;
  logic [2:0]  bus_cyc, bus_stb, bus_we, ack, err;
  logic [31:0] adr   [3];
  logic [3:0]  sel   [3];
  logic [31:0] dat_w [3];
  logic [31:0] dat_r [3];

  int checks   = 0;
  int failures = 0;
  int cyc_cnt  = 0;

  typedef struct packed {
    logic [1:0]  dut;
    logic        is_err;
    logic        chk_data;
    logic [31:0] data;
    int          term;
  } exp_t;

  exp_t exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  or1200_wb_ram_slave #(.MEM_WORDS(1024), .WAIT_STATES(1), .BASE_ADDR(32'h0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n[0]), .wb_cyc_i(bus_cyc[0]), .wb_stb_i(bus_stb[0]),
    .wb_we_i(bus_we[0]), .wb_adr_i(adr[0]), .wb_sel_i(sel[0]), .wb_dat_i(dat_w[0]),
    .wb_dat_o(dat_r[0]), .wb_ack_o(ack[0]), .wb_err_o(err[0]));

  or1200_wb_ram_slave #(.MEM_WORDS(1024), .WAIT_STATES(3), .BASE_ADDR(32'h0)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n[1]), .wb_cyc_i(bus_cyc[1]), .wb_stb_i(bus_stb[1]),
    .wb_we_i(bus_we[1]), .wb_adr_i(adr[1]), .wb_sel_i(sel[1]), .wb_dat_i(dat_w[1]),
    .wb_dat_o(dat_r[1]), .wb_ack_o(ack[1]), .wb_err_o(err[1]));

  or1200_wb_ram_slave #(.MEM_WORDS(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n[2]), .wb_cyc_i(bus_cyc[2]), .wb_stb_i(bus_stb[2]),
    .wb_we_i(bus_we[2]), .wb_adr_i(adr[2]), .wb_sel_i(sel[2]), .wb_dat_i(dat_w[2]),
    .wb_dat_o(dat_r[2]), .wb_ack_o(ack[2]), .wb_err_o(err[2]));

  function automatic int ws_of(input int k);
    case (k)
      0:       return 1;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  // Called just after a rising edge; returns just after the edge ending the termination cycle.
  task automatic req(input int k, input bit w, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] d, input bit exp_err, input logic [31:0] exp_d,
                     input bit hold);
    exp_t e;
    int   waitc;
    bus_cyc[k] = 1'b1;
    bus_stb[k] = 1'b1;
    bus_we[k]  = w;
    adr[k]     = a;
    sel[k]     = s;
    dat_w[k]   = d;
    e.dut      = 2'(k);
    e.is_err   = exp_err;
    e.chk_data = exp_err | ~w;
    e.data     = exp_d;
    e.term     = cyc_cnt + ws_of(k) + 1;
    exp_q.push_back(e);
    waitc = 0;
    forever begin
      @(negedge clk);
      if (ack[k] || err[k]) break;
      waitc++;
      if (waitc > 20) begin
        checks++;
        failures++;
        $display("FAIL timeout dut=%0d adr=%h: got no termination, required one within 20 cycles", k, a);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      bus_cyc[k] = 1'b0;
      bus_stb[k] = 1'b0;
    end
  endtask

  // Monitor: pops one expectation per termination; idle cycles must show zero read data.
  initial begin
    logic [2:0] prev_term;
    exp_t       e;
    prev_term = 3'b000;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (ack[k] || err[k]) begin
          checks++;
          if ((ack[k] && err[k]) || prev_term[k]) begin
            failures++;
            $display("FAIL term_shape dut=%0d ack=%0b err=%0b prev=%0b: required one single-cycle pulse",
                     k, ack[k], err[k], prev_term[k]);
          end
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_term dut=%0d ack=%0b err=%0b: required no termination", k, ack[k], err[k]);
          end else begin
            e = exp_q.pop_front();
            checks++;
            if (int'(e.dut) != k) begin
              failures++;
              $display("FAIL term_dut got=%0d required=%0d", k, e.dut);
            end
            checks++;
            if (err[k] != e.is_err || ack[k] == e.is_err) begin
              failures++;
              $display("FAIL term_kind dut=%0d ack=%0b err=%0b required_err=%0b", k, ack[k], err[k], e.is_err);
            end
            checks++;
            if (cyc_cnt != e.term) begin
              failures++;
              $display("FAIL latency dut=%0d term_cycle=%0d required=%0d", k, cyc_cnt, e.term);
            end
            if (e.chk_data) begin
              checks++;
              if (dat_r[k] !== e.data) begin
                failures++;
                $display("FAIL read_data dut=%0d got=%h required=%h", k, dat_r[k], e.data);
              end
            end
            $display("TXN dut=%0d cycle=%0d ack=%0b err=%0b dat=%h", k, cyc_cnt, ack[k], err[k], dat_r[k]);
          end
        end else begin
          checks++;
          if (dat_r[k] !== 32'd0) begin
            failures++;
            $display("FAIL idle_dat dut=%0d got=%h required=00000000", k, dat_r[k]);
          end
        end
        prev_term[k] = ack[k] | err[k];
      end
    end
  end

  initial begin
    int n;
    rst_n   = 3'b000;
    bus_cyc = 3'b000;
    bus_stb = 3'b000;
    bus_we  = 3'b000;
    for (int k = 0; k < 3; k++) begin
      adr[k] = 32'd0; sel[k] = 4'd0; dat_w[k] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ack[k] !== 1'b0 || err[k] !== 1'b0 || dat_r[k] !== 32'd0) begin
        failures++;
        $display("FAIL reset_outputs dut=%0d ack=%0b err=%0b dat=%h required all zero", k, ack[k], err[k], dat_r[k]);
      end
    end
    rst_n = 3'b111;
    repeat (3) @(posedge clk);
    #1;

    // One wait state: basic write/read, byte lanes, errors, sel=0, top word
    req(0, 1, 32'h10,  4'hF, 32'hDEADBEEF, 0, 32'h0,        0);
    req(0, 0, 32'h10,  4'hF, 32'h0,        0, 32'hDEADBEEF, 0);
    req(0, 1, 32'h20,  4'hF, 32'h11223344, 0, 32'h0,        0);
    req(0, 1, 32'h20,  4'h4, 32'hAABBCCDD, 0, 32'h0,        0);
    req(0, 0, 32'h20,  4'hF, 32'h0,        0, 32'h11BB3344, 0);
    req(0, 0, 32'h22,  4'hF, 32'h0,        1, 32'h0,        0);
    req(0, 0, 32'h1000,4'hF, 32'h0,        1, 32'h0,        0);
    req(0, 1, 32'h11,  4'hF, 32'h0,        1, 32'h0,        0);
    req(0, 1, 32'h1000,4'hF, 32'h0,        1, 32'h0,        0);
    req(0, 0, 32'h10,  4'hF, 32'h0,        0, 32'hDEADBEEF, 0);
    req(0, 0, 32'h20,  4'h0, 32'h0,        0, 32'h11BB3344, 0);
    req(0, 1, 32'h10,  4'h0, 32'h0,        0, 32'h0,        0);
    req(0, 0, 32'h10,  4'hF, 32'h0,        0, 32'hDEADBEEF, 0);
    req(0, 1, 32'hFFC, 4'hF, 32'h5A5AA5A5, 0, 32'h0,        0);
    req(0, 0, 32'hFFC, 4'hF, 32'h0,        0, 32'h5A5AA5A5, 0);

    // Reset during WAIT discards the in-flight write
    req(0, 1, 32'h40,  4'hF, 32'h0BADF00D, 0, 32'h0,        0);
    bus_cyc[0] = 1'b1; bus_stb[0] = 1'b1; bus_we[0] = 1'b1;
    adr[0] = 32'h40; sel[0] = 4'hF; dat_w[0] = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    rst_n[0] = 1'b0;
    bus_cyc[0] = 1'b0; bus_stb[0] = 1'b0;
    #1;
    checks++;
    if (ack[0] !== 1'b0 || err[0] !== 1'b0 || dat_r[0] !== 32'd0) begin
      failures++;
      $display("FAIL reset_in_wait ack=%0b err=%0b dat=%h required all zero", ack[0], err[0], dat_r[0]);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    req(0, 0, 32'h40,  4'hF, 32'h0,        0, 32'h0BADF00D, 0);

    // Three wait states: abort during WAIT leaves memory untouched
    req(1, 1, 32'h30,  4'hF, 32'h01020304, 0, 32'h0,        0);
    bus_cyc[1] = 1'b1; bus_stb[1] = 1'b1; bus_we[1] = 1'b1;
    adr[1] = 32'h30; sel[1] = 4'hF; dat_w[1] = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    bus_cyc[1] = 1'b0; bus_stb[1] = 1'b0;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack[1] || err[1]) n++;
    end
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL abort_term got=%0d terminations required=0", n);
    end
    @(posedge clk);
    #1;
    req(1, 0, 32'h30,  4'hF, 32'h0,        0, 32'h01020304, 0);

    // Zero wait states: back-to-back reads ack every other cycle
    req(2, 1, 32'h0,   4'hF, 32'hCAFE0000, 0, 32'h0,        0);
    req(2, 1, 32'h4,   4'hF, 32'h0000BABE, 0, 32'h0,        0);
    req(2, 0, 32'h0,   4'hF, 32'h0,        0, 32'hCAFE0000, 1);
    req(2, 0, 32'h4,   4'hF, 32'h0,        0, 32'h0000BABE, 0);

    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d pending required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
